// File: rtl/ls_order_queue_if.sv
// Dispatch, CDB broadcast, memory-issue and store-data-report signals of the
// load/store order queue.
interface ls_order_queue_if #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                        disp_en_in;
    logic                        disp_is_store_in;
    logic [1:0]                  disp_size_in;
    logic                        disp_unsigned_in;
    logic [DATA_W-1:0]           disp_vj_in;
    logic [ROB_W-1:0]            disp_qj_in;
    logic [DATA_W-1:0]           disp_vk_in;
    logic [ROB_W-1:0]            disp_qk_in;
    logic [DATA_W-1:0]           disp_imm_in;
    logic [ROB_W-1:0]            disp_dest_in;
    logic [NUM_CDB-1:0]          cdb_en_in;
    logic [NUM_CDB*ROB_W-1:0]    cdb_dest_in;
    logic [NUM_CDB*DATA_W-1:0]   cdb_value_in;
    logic                        lbuf_rdy_in;
    logic                        full_out;
    logic [CNT_W-1:0]            count_out;
    logic                        au_en_out;
    logic [DATA_W-1:0]           au_addr_out;
    logic [ROB_W-1:0]            au_dest_out;
    logic                        au_is_store_out;
    logic [1:0]                  au_size_out;
    logic                        au_unsigned_out;
    logic                        rob_en_out;
    logic [ROB_W-1:0]            rob_dest_out;
    logic [DATA_W-1:0]           rob_value_out;

    modport master (
        output disp_en_in, disp_is_store_in, disp_size_in, disp_unsigned_in,
               disp_vj_in, disp_qj_in, disp_vk_in, disp_qk_in, disp_imm_in,
               disp_dest_in, cdb_en_in, cdb_dest_in, cdb_value_in, lbuf_rdy_in,
        input  full_out, count_out, au_en_out, au_addr_out, au_dest_out,
               au_is_store_out, au_size_out, au_unsigned_out,
               rob_en_out, rob_dest_out, rob_value_out
    );

    modport slave (
        input  disp_en_in, disp_is_store_in, disp_size_in, disp_unsigned_in,
               disp_vj_in, disp_qj_in, disp_vk_in, disp_qk_in, disp_imm_in,
               disp_dest_in, cdb_en_in, cdb_dest_in, cdb_value_in, lbuf_rdy_in,
        output full_out, count_out, au_en_out, au_addr_out, au_dest_out,
               au_is_store_out, au_size_out, au_unsigned_out,
               rob_en_out, rob_dest_out, rob_value_out
    );
endinterface

// File: rtl/ls_order_queue.sv
// In-order load/store queue: captures operands from the CDB, reports store data
// to the ROB oldest-first and issues memory ops strictly from the head.
module ls_order_queue #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input logic            clk_in,
    input logic            rst_in,
    input logic            rdy_in,
    input logic            flush_in,
    ls_order_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ROB_W-1:0]  cdb_dest  [NUM_CDB];
    logic [DATA_W-1:0] cdb_value [NUM_CDB];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CDB; gi++) begin : g_cdb
            assign cdb_dest[gi]  = bus.cdb_dest_in[gi*ROB_W +: ROB_W];
            assign cdb_value[gi] = bus.cdb_value_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Control state (reset) and per-entry payload (no reset needed: gated by valid)
    logic [PTR_W-1:0]  head_reg, head_next, tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DEPTH-1:0]  valid_reg, valid_next, reported_reg, reported_next;
    logic [DEPTH-1:0]  is_store_reg, is_store_next, uns_reg, uns_next;
    logic [1:0]        size_reg  [DEPTH];
    logic [1:0]        size_next [DEPTH];
    logic [DATA_W-1:0] vj_reg [DEPTH], vj_next [DEPTH], vk_reg [DEPTH], vk_next [DEPTH];
    logic [DATA_W-1:0] imm_reg [DEPTH], imm_next [DEPTH];
    logic [ROB_W-1:0]  qj_reg [DEPTH], qj_next [DEPTH], qk_reg [DEPTH], qk_next [DEPTH];
    logic [ROB_W-1:0]  dest_reg [DEPTH], dest_next [DEPTH];

    logic              au_en_reg, au_is_store_reg, au_unsigned_reg;
    logic [DATA_W-1:0] au_addr_reg, au_addr_next;
    logic [ROB_W-1:0]  au_dest_reg;
    logic [1:0]        au_size_reg;
    logic              rob_en_reg;
    logic [ROB_W-1:0]  rob_dest_reg;
    logic [DATA_W-1:0] rob_value_reg, rob_value_next;

    logic              pop_ok, disp_ok, rep_found;
    logic [PTR_W-1:0]  rep_idx, scan_idx;
    logic [DATA_W-1:0] disp_vj, disp_vk;
    logic [ROB_W-1:0]  disp_qj, disp_qk;

    // Head may leave only with its base ready; a store also needs its data already reported.
    assign pop_ok  = (count_reg != '0) && (qj_reg[head_reg] == '0) &&
                     (is_store_reg[head_reg] ? reported_reg[head_reg] : bus.lbuf_rdy_in);
    assign disp_ok = bus.disp_en_in && (count_reg != FULL_CNT);
    assign au_addr_next = vj_reg[head_reg] + imm_reg[head_reg];

    always_comb begin
        valid_next    = valid_reg;
        reported_next = reported_reg;
        is_store_next = is_store_reg;
        uns_next      = uns_reg;
        size_next     = size_reg;
        vj_next       = vj_reg;
        qj_next       = qj_reg;
        vk_next       = vk_reg;
        qk_next       = qk_reg;
        imm_next      = imm_reg;
        dest_next     = dest_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        rep_found     = 1'b0;
        rep_idx       = '0;
        scan_idx      = '0;
        disp_vj       = bus.disp_vj_in;
        disp_qj       = bus.disp_qj_in;
        disp_vk       = bus.disp_vk_in;
        disp_qk       = bus.disp_qk_in;

        // Walk channels from high to low so the lowest matching channel wins.
        for (int i = 0; i < DEPTH; i++) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (valid_reg[i] && bus.cdb_en_in[c]) begin
                    if (qj_reg[i] != '0 && cdb_dest[c] == qj_reg[i]) begin
                        vj_next[i] = cdb_value[c];
                        qj_next[i] = '0;
                    end
                    if (qk_reg[i] != '0 && cdb_dest[c] == qk_reg[i]) begin
                        vk_next[i] = cdb_value[c];
                        qk_next[i] = '0;
                    end
                end
            end
        end

        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (bus.cdb_en_in[c]) begin
                if (bus.disp_qj_in != '0 && cdb_dest[c] == bus.disp_qj_in) begin
                    disp_vj = cdb_value[c];
                    disp_qj = '0;
                end
                if (bus.disp_qk_in != '0 && cdb_dest[c] == bus.disp_qk_in) begin
                    disp_vk = cdb_value[c];
                    disp_qk = '0;
                end
            end
        end

        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (!rep_found && valid_reg[scan_idx] && is_store_reg[scan_idx] &&
                qk_reg[scan_idx] == '0 && !reported_reg[scan_idx]) begin
                rep_found = 1'b1;
                rep_idx   = scan_idx;
            end
        end
        if (rep_found)
            reported_next[rep_idx] = 1'b1;

        if (pop_ok) begin
            valid_next[head_reg] = 1'b0;
            head_next            = head_reg + PTR_W'(1);
        end

        if (disp_ok) begin
            valid_next[tail_reg]    = 1'b1;
            reported_next[tail_reg] = 1'b0;
            is_store_next[tail_reg] = bus.disp_is_store_in;
            uns_next[tail_reg]      = bus.disp_unsigned_in;
            size_next[tail_reg]     = bus.disp_size_in;
            vj_next[tail_reg]       = disp_vj;
            qj_next[tail_reg]       = disp_qj;
            vk_next[tail_reg]       = disp_vk;
            qk_next[tail_reg]       = disp_qk;
            imm_next[tail_reg]      = bus.disp_imm_in;
            dest_next[tail_reg]     = bus.disp_dest_in;
            tail_next               = tail_reg + PTR_W'(1);
        end

        count_next = count_reg + CNT_W'(disp_ok) - CNT_W'(pop_ok);

        case (size_reg[rep_idx])
            2'b00:   rob_value_next = DATA_W'(vk_reg[rep_idx][7:0]);
            2'b01:   rob_value_next = DATA_W'(vk_reg[rep_idx][15:0]);
            default: rob_value_next = vk_reg[rep_idx];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            valid_reg       <= '0;
            reported_reg    <= '0;
            au_en_reg       <= 1'b0;
            au_addr_reg     <= '0;
            au_dest_reg     <= '0;
            au_is_store_reg <= 1'b0;
            au_size_reg     <= '0;
            au_unsigned_reg <= 1'b0;
            rob_en_reg      <= 1'b0;
            rob_dest_reg    <= '0;
            rob_value_reg   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head_reg     <= '0;
                tail_reg     <= '0;
                count_reg    <= '0;
                valid_reg    <= '0;
                reported_reg <= '0;
                au_en_reg    <= 1'b0;
                rob_en_reg   <= 1'b0;
            end else begin
                head_reg     <= head_next;
                tail_reg     <= tail_next;
                count_reg    <= count_next;
                valid_reg    <= valid_next;
                reported_reg <= reported_next;
                au_en_reg    <= pop_ok;
                rob_en_reg   <= rep_found;
                if (pop_ok) begin
                    au_addr_reg     <= au_addr_next;
                    au_dest_reg     <= dest_reg[head_reg];
                    au_is_store_reg <= is_store_reg[head_reg];
                    au_size_reg     <= size_reg[head_reg];
                    au_unsigned_reg <= uns_reg[head_reg];
                end
                if (rep_found) begin
                    rob_dest_reg  <= dest_reg[rep_idx];
                    rob_value_reg <= rob_value_next;
                end
            end
        end else begin
            au_en_reg  <= 1'b0;
            rob_en_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush_in) begin
            is_store_reg <= is_store_next;
            uns_reg      <= uns_next;
            size_reg     <= size_next;
            vj_reg       <= vj_next;
            qj_reg       <= qj_next;
            vk_reg       <= vk_next;
            qk_reg       <= qk_next;
            imm_reg      <= imm_next;
            dest_reg     <= dest_next;
        end
    end

    assign bus.full_out        = (count_reg == FULL_CNT);
    assign bus.count_out       = count_reg;
    assign bus.au_en_out       = au_en_reg;
    assign bus.au_addr_out     = au_addr_reg;
    assign bus.au_dest_out     = au_dest_reg;
    assign bus.au_is_store_out = au_is_store_reg;
    assign bus.au_size_out     = au_size_reg;
    assign bus.au_unsigned_out = au_unsigned_reg;
    assign bus.rob_en_out      = rob_en_reg;
    assign bus.rob_dest_out    = rob_dest_reg;
    assign bus.rob_value_out   = rob_value_reg;
endmodule
